counter_updown_mod: RTL

- Parametrised successor to the basic binary counter. Adds configurable width and modulus, up/down counting, synchronous parallel load, and separate carry/borrow outputs.
- Carry/borrow are combinational, so counters cascade directly (carry/borrow of stage N drives enable of stage N+1).
- Used as a general-purpose timebase, divider and BCD-digit building block (MODULO=10) in the Digital_II counter designs.

---
 rtl/counter_pkg.sv | 35 +++
 rtl/prescaler_tick.sv | 46 ++++
 rtl/counter_updown_mod.sv | 99 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: direction encodings,
// standard digit sizes and a constant-width helper for prescaler state.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int    BCD_NBITS  = 4;
  localparam longint BCD_MODULO = 10;
  localparam int    HEX_NBITS  = 4;
  localparam longint HEX_MODULO = 16;

  // What the counter register does on the coming clock edge.
  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } count_op_e;

  // Ceiling log2; returns 0 for values of 0 or 1, so callers needing a
  // register width must apply their own minimum of one bit.
  function automatic int clog2(input longint value);
    longint rem;
    int     bits;
    rem  = value - 1;
    bits = 0;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Divide-by-PRESCALE enable generator. Counts enabled cycles and raises tick
// combinationally in the last cycle of each group; clear restarts the group.
module prescaler_tick
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? clog2(longint'(PRESCALE)) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = enable & (cnt_q == LAST);

  // Next prescaler state: clear wins, then wrap on tick, hold when idle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Prescaler state register, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Modulo-N up/down counter with synchronous clamped load and combinational
// carry/borrow for direct cascading. Defining COUNTER_PRESCALE_EN inserts a
// prescaler so the counter only advances once every PRESCALE enabled cycles.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int     NBITS    = 4,
  parameter longint MODULO   = 16,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [NBITS-1:0] load_value,
  output logic             carry,
  output logic             borrow,
  output logic             terminal,
  output logic [NBITS-1:0] counter
);

  if ((NBITS < 1) || (NBITS > 32)) begin : g_bad_nbits
    $error("counter_updown_mod: NBITS must be 1..32");
  end
  if ((MODULO < 2) || (MODULO > (longint'(1) << NBITS))) begin : g_bad_modulo
    $error("counter_updown_mod: MODULO must be 2..2**NBITS");
  end
  if ((PRESCALE < 1) || (PRESCALE > 65535)) begin : g_bad_prescale
    $error("counter_updown_mod: PRESCALE must be 1..65535");
  end

  localparam logic [NBITS-1:0] MAX_VAL = NBITS'(MODULO - 1);

  logic             adv;
  logic             at_max;
  logic             at_zero;
  count_op_e        op;
  logic [NBITS-1:0] counter_q;
  logic [NBITS-1:0] counter_d;

`ifdef COUNTER_PRESCALE_EN
  logic tick;

  prescaler_tick #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .clear (load),
    .tick  (tick)
  );

  assign adv = enable & tick & ~load;
`else
  assign adv = enable & ~load;
`endif

  assign at_max  = (counter_q == MAX_VAL);
  assign at_zero = (counter_q == '0);

  // Wrap flags are gated by reset so an aborted edge never reports a wrap.
  assign carry    = ~reset & adv & (up_down == DIR_UP) & at_max;
  assign borrow   = ~reset & adv & (up_down == DIR_DOWN) & at_zero;
  assign terminal = (up_down == DIR_UP) ? at_max : at_zero;
  assign counter  = counter_q;

  // Resolve load-over-count priority into a single operation.
  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (adv) begin
      op = (up_down == DIR_UP) ? OP_UP : OP_DOWN;
    end
  end

  // Next count: clamp loads into range, wrap by compare so any modulus works.
  always_comb begin
    counter_d = counter_q;
    unique case (op)
      OP_LOAD: counter_d = (load_value > MAX_VAL) ? MAX_VAL : load_value;
      OP_UP:   counter_d = at_max ? '0 : (counter_q + NBITS'(1));
      OP_DOWN: counter_d = at_zero ? MAX_VAL : (counter_q - NBITS'(1));
      default: counter_d = counter_q;
    endcase
  end

  // Count register, forced to zero immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q <= '0;
    end else begin
      counter_q <= counter_d;
    end
  end

endmodule
